// File: rtl/datapath_ctrl.sv
// Sequencing controller for the 4-bit accumulator datapath: LOAD / INC / ROT (and QLOAD
// when DATAPATH_CTRL_QLOAD_EN is defined), writing the result to R1 and pulsing done.
module datapath_ctrl #(
  parameter logic [2:0] ALU_ADD_CODE  = 3'b000,
  parameter logic [2:0] ALU_IDLE_CODE = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] count,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       mux_2x1_R1_sel,
  output logic       mux_2x1_alu_a_sel,
  output logic       mux_2x1_acc_sel,
  output logic       acc_load_sel,
  output logic       q_dir_sel,
  output logic [2:0] alu_control
);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SHIFT, S_WRITE, S_DONE} state_t;

  localparam logic [1:0] OP_INC   = 2'd1;
  localparam logic [1:0] OP_ROT   = 2'd2;
  localparam logic [1:0] OP_QLOAD = 2'd3;

  state_t     state, state_nx;
  logic [1:0] op_q;
  logic [3:0] count_q;
  logic [3:0] cnt;
  logic       err_q;
  logic       ready, legal, accept;

  assign ready = (state == S_IDLE) || (state == S_DONE);
`ifdef DATAPATH_CTRL_QLOAD_EN
  assign legal = 1'b1;
`else
  assign legal = (op != OP_QLOAD);
`endif
  assign accept = ready && start && legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      count_q <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= ready && start && !legal;
      if (accept) begin
        op_q    <= op;
        count_q <= count;
      end
      if (state == S_EXEC)
        cnt <= count_q;
      else if (state == S_SHIFT)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_nx          = state;
    busy              = 1'b0;
    done              = 1'b0;
    mux_2x1_R1_sel    = 1'b0;
    mux_2x1_alu_a_sel = 1'b0;
    mux_2x1_acc_sel   = 1'b0;
    acc_load_sel      = 1'b0;
    alu_control       = ALU_IDLE_CODE;
    case (state)
      S_IDLE: state_nx = accept ? S_EXEC : S_IDLE;
      S_EXEC: begin
        busy              = 1'b1;
        acc_load_sel      = 1'b1;
        alu_control       = ALU_ADD_CODE;
        mux_2x1_alu_a_sel = (op_q == OP_INC);
        mux_2x1_acc_sel   = (op_q == OP_QLOAD);
        state_nx          = (op_q == OP_ROT && count_q != 4'd0) ? S_SHIFT : S_WRITE;
      end
      // cnt holds the remaining shifts including the current one
      S_SHIFT: begin
        busy     = 1'b1;
        state_nx = (cnt == 4'd1) ? S_WRITE : S_SHIFT;
      end
      S_WRITE: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = accept ? S_EXEC : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign err = err_q;
`ifdef DATAPATH_CTRL_QLOAD_EN
  assign q_dir_sel = busy && count_q[0];
`else
  assign q_dir_sel = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: a small datapath environment driven by the DUT's controls,
// with results checked against the arithmetic definition of each operation.
module tb_datapath_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = '0;
  logic [3:0] count = '0;
  logic [3:0] din = '0;
  logic       busy, done, err, r1_sel, alu_a_sel, acc_sel, acc_load_sel, q_dir_sel;
  logic [2:0] alu_control;

  int vectors = 0;
  int miscompares = 0;

  datapath_ctrl #(.ALU_ADD_CODE(3'b000), .ALU_IDLE_CODE(3'b000)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .count(count),
    .busy(busy), .done(done), .err(err),
    .mux_2x1_R1_sel(r1_sel), .mux_2x1_alu_a_sel(alu_a_sel), .mux_2x1_acc_sel(acc_sel),
    .acc_load_sel(acc_load_sel), .q_dir_sel(q_dir_sel), .alu_control(alu_control)
  );

  always #5 clk = ~clk;

  // Datapath environment: registers without enables, as the controller expects.
  logic [3:0] r0 = '0, acc = '0, r1 = '0, q = 4'b0110;
  logic [3:0] alu_a, alu_out;
  assign alu_a   = alu_a_sel ? 4'd1 : 4'd0;
  assign alu_out = (alu_control == 3'b000) ? alu_a + r0 : 4'd0;
  always @(posedge clk) begin
    r0  <= din;
    acc <= acc_load_sel ? (acc_sel ? q : alu_out) : {acc[0], acc[3:1]};
    r1  <= r1_sel ? alu_out : acc;
    q   <= q_dir_sel ? {q[2:0], q[3]} : {q[0], q[3:1]};
  end

  logic tr_busy [0:31], tr_load [0:31], tr_alua [0:31], tr_accsel [0:31], tr_qdir [0:31];
  logic [3:0] tr_q [0:31];

  function automatic logic [3:0] ref_result(input logic [1:0] o, input logic [3:0] d,
                                            input logic [3:0] c);
    int r;
    r = c % 4;
    case (o)
      2'd0: return d;
      2'd1: return d + 4'd1;
      2'd2: return 4'(((d >> r) | (d << (4 - r))) & 4'hF);
      default: return 4'h0;
    endcase
  endfunction

  // Call at a negedge; presents one start and traces cycles until done or a budget expires.
  task automatic run_op(input logic [1:0] o, input logic [3:0] d, input logic [3:0] c,
                        output int lat, output logic [3:0] res);
    din = d; op = o; count = c; start = 1'b1;
    @(posedge clk);
    lat = -1; res = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = 1'b0;
      tr_busy[k] = busy; tr_load[k] = acc_load_sel; tr_alua[k] = alu_a_sel;
      tr_accsel[k] = acc_sel; tr_qdir[k] = q_dir_sel; tr_q[k] = q;
      if (done) begin
        lat = k; res = r1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat; logic [3:0] res;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, err, r1_sel, alu_a_sel, acc_sel, acc_load_sel, q_dir_sel, alu_control} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 0", {busy, done, err, r1_sel, alu_a_sel, acc_sel,
               acc_load_sel, q_dir_sel, alu_control});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done);
    end
    run_op(2'd0, 4'h3, 4'h0, lat, res);
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("FAIL first_latency got %0d want 3", lat);
    end
  endtask

  task automatic test_load();
    int lat; logic [3:0] res;
    @(negedge clk);
    run_op(2'd0, 4'hA, 4'h0, lat, res);
    vectors++;
    if (lat !== 3 || res !== 4'hA) begin
      miscompares++;
      $display("FAIL load got lat=%0d out=%h want lat=3 out=a", lat, res);
    end
    vectors++;
    if (tr_alua[1] !== 1'b0 || tr_load[1] !== 1'b1 || tr_busy[1] !== 1'b1 || tr_busy[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL load_exec got alua=%b load=%b busy=%b%b want 0 1 11",
               tr_alua[1], tr_load[1], tr_busy[1], tr_busy[2]);
    end
  endtask

  task automatic test_inc_wrap();
    int lat; logic [3:0] res;
    @(negedge clk);
    run_op(2'd1, 4'hF, 4'h0, lat, res);
    vectors++;
    if (lat !== 3 || res !== 4'h0) begin
      miscompares++;
      $display("FAIL inc_wrap got lat=%0d out=%h want lat=3 out=0", lat, res);
    end
    vectors++;
    if (tr_alua[1] !== 1'b1 || tr_alua[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL inc_alua got exec=%b write=%b want 1 0", tr_alua[1], tr_alua[2]);
    end
  endtask

  task automatic test_rot();
    int lat; logic [3:0] res;
    @(negedge clk);
    run_op(2'd2, 4'b0001, 4'd3, lat, res);
    vectors++;
    if (lat !== 6 || res !== 4'b0010) begin
      miscompares++;
      $display("FAIL rot3 got lat=%0d out=%b want lat=6 out=0010", lat, res);
    end
    vectors++;
    if (tr_load[2] !== 1'b0 || tr_load[3] !== 1'b0 || tr_load[4] !== 1'b0 || tr_busy[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL rot3_shift got load=%b%b%b busy=%b want 000 1",
               tr_load[2], tr_load[3], tr_load[4], tr_busy[4]);
    end
    @(negedge clk);
    run_op(2'd2, 4'b0001, 4'd0, lat, res);
    vectors++;
    if (lat !== 3 || res !== 4'b0001) begin
      miscompares++;
      $display("FAIL rot0 got lat=%0d out=%b want lat=3 out=0001", lat, res);
    end
    @(negedge clk);
    run_op(2'd2, 4'b1011, 4'd15, lat, res);
    vectors++;
    if (lat !== 18 || res !== ref_result(2'd2, 4'b1011, 4'd15)) begin
      miscompares++;
      $display("FAIL rot15 got lat=%0d out=%b want lat=18 out=%b", lat, res,
               ref_result(2'd2, 4'b1011, 4'd15));
    end
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [3:0] res, d, c; logic [1:0] o;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      o = 2'($urandom_range(0, 2)); d = 4'($urandom); c = 4'($urandom);
      exp_lat = 3 + ((o == 2'd2) ? int'(c) : 0);
      run_op(o, d, c, lat, res);
      vectors++;
      if (lat !== exp_lat || res !== ref_result(o, d, c)) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d in=%h cnt=%0d got lat=%0d out=%h want lat=%0d out=%h",
                 i, o, d, c, lat, res, exp_lat, ref_result(o, d, c));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [3:0] res;
    @(negedge clk);
    run_op(2'd1, 4'h6, 4'h0, lat, res);
    run_op(2'd0, 4'h9, 4'h0, lat, res);
    vectors++;
    if (tr_busy[1] !== 1'b1 || lat !== 3 || res !== 4'h9) begin
      miscompares++;
      $display("FAIL back_to_back got busy1=%b lat=%0d out=%h want 1 3 9", tr_busy[1], lat, res);
    end
  endtask

  task automatic test_ignore_busy();
    int lat; logic seen_busy;
    @(negedge clk);
    din = 4'h5; op = 2'd0; count = 4'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din = 4'h9; op = 2'd1;
    lat = -1;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin lat = k; break; end
    end
    vectors++;
    if (lat !== 3 || r1 !== 4'h5) begin
      miscompares++;
      $display("FAIL ignore_busy got lat=%0d out=%h want lat=3 out=5", lat, r1);
    end
    seen_busy = 1'b0;
    repeat (6) begin @(negedge clk); if (busy) seen_busy = 1'b1; end
    vectors++;
    if (seen_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL not_queued got busy=%b want 0", seen_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    @(negedge clk);
    din = 4'h1; op = 2'd2; count = 4'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got busy=%b done=%b err=%b want 0 0 0", busy, done, err);
    end
    seen_done = 1'b0;
    repeat (10) begin @(negedge clk); if (done || busy) seen_done = 1'b1; end
    vectors++;
    if (seen_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet got activity=%b want 0", seen_done);
    end
  endtask

  task automatic test_config();
`ifdef DATAPATH_CTRL_QLOAD_EN
    int lat; logic [3:0] res;
    @(negedge clk);
    run_op(2'd3, 4'h0, 4'd1, lat, res);
    vectors++;
    if (lat !== 3 || tr_qdir[1] !== 1'b1 || tr_qdir[2] !== 1'b1 || tr_qdir[3] !== 1'b0 ||
        tr_accsel[1] !== 1'b1 || tr_accsel[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL qload_ctrl got lat=%0d qdir=%b%b%b accsel=%b%b want 3 110 10", lat,
               tr_qdir[1], tr_qdir[2], tr_qdir[3], tr_accsel[1], tr_accsel[2]);
    end
    vectors++;
    if (res !== tr_q[1]) begin
      miscompares++;
      $display("FAIL qload_result got %h want %h", res, tr_q[1]);
    end
`else
    logic activity;
    @(negedge clk);
    op = 2'd3; count = 4'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_op got err=%b busy=%b done=%b want 1 0 0", err, busy, done);
    end
    activity = 1'b0;
    repeat (5) begin @(negedge clk); if (err || busy || done) activity = 1'b1; end
    vectors++;
    if (activity !== 1'b0 || q_dir_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_after got activity=%b qdir=%b want 0 0", activity, q_dir_sel);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_inc_wrap();
    test_rot();
    test_random();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_config();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // done and err must never coincide
  always @(negedge clk) begin
    if (done && err) begin
      vectors++;
      miscompares++;
      $display("FAIL done_err_overlap got done=1 err=1 want not both");
    end
  end

endmodule
